// File: rtl/powerup_drop_controller_pkg.sv
// Purpose : shared types and constants for the power-up drop controller and its helpers.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package powerup_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FALLING,
        COLLECTED
    } drop_state_t;

    typedef enum logic {
        PU_TURBO,
        PU_GODMODE
    } powerup_type_t;

    // Fibonacci feedback taps at bit positions 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Height above the discard line where the object starts blinking.
    localparam int BLINK_ZONE = 64;

endpackage

// File: rtl/powerup_drop_controller_if.sv
// Purpose : bundles frame/collision inputs and drawing/pickup outputs of the drop controller.
// Latency : n/a (wires only).
// Backpressure: none; every signal is a level or a one-cycle pulse.
// Ports   : gameActive, startOfFrame, playerPickup (towards controller);
//           topLeftX, topLeftY, powerupVisible, powerupType,
//           TurboCollision, GodModeCollision (from controller).
// Modports: master = frame/collision logic side, slave = drop controller side.
interface powerup_drop_controller_if;

    logic               gameActive;
    logic               startOfFrame;
    logic               playerPickup;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               powerupVisible;
    logic               powerupType;
    logic               TurboCollision;
    logic               GodModeCollision;

    modport master (
        output gameActive, startOfFrame, playerPickup,
        input  topLeftX, topLeftY, powerupVisible, powerupType,
               TurboCollision, GodModeCollision
    );

    modport slave (
        input  gameActive, startOfFrame, playerPickup,
        output topLeftX, topLeftY, powerupVisible, powerupType,
               TurboCollision, GodModeCollision
    );

endinterface

// File: rtl/powerup_drop_controller_lfsr16.sv
// Purpose : free-running 16-bit Fibonacci LFSR used as a cheap spawn randomiser.
// Latency : advances one step on every clock; output is the register itself.
// Backpressure: none; never stalls.
// Ports   : clk, reset (async, active-high, loads SEED), o_lfsr (current state).
module lfsr16
    import powerup_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/powerup_drop_controller.sv
// Purpose : spawns one falling power-up at a time, moves it per frame, pulses on pickup.
// Latency : pickup sampled at edge N gives the matching collision pulse during cycle N+1.
// Backpressure: none; inputs are levels/pulses, outputs are registered pulses and levels.
// Ports   : clk, reset (async, active-high), bus (powerup_drop_controller_if.slave).
// Option  : define POWERUP_BLINK_EN to blink the object near the bottom of the screen.
module powerup_drop_controller
    import powerup_pkg::*;
#(
    parameter int          SPAWN_FRAMES = 300,
    parameter int          FALL_SPEED   = 2,
    parameter int          TOP_Y        = 0,
    parameter int          BOTTOM_Y     = 448,
    parameter int          X_MIN        = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    powerup_drop_controller_if.slave   bus
);

    localparam int                 CW       = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(SPAWN_FRAMES - 1);
    localparam logic signed [10:0] Y_TOP    = 11'(TOP_Y);
    localparam logic signed [10:0] Y_BOT    = 11'(BOTTOM_Y);
    localparam logic signed [10:0] Y_STEP   = 11'(FALL_SPEED);
    localparam logic signed [10:0] X_LEFT   = 11'(X_MIN);

    drop_state_t        r_state;
    drop_state_t        w_next;
    logic [CW-1:0]      r_frame_cnt;
    logic signed [10:0] r_x;
    logic signed [10:0] r_y;
    logic signed [10:0] w_y_next;
    powerup_type_t      r_type;
    logic               r_turbo;
    logic               r_god;
    logic [15:0]        w_lfsr;
    logic               w_unused_lfsr;
    logic               w_spawn;
    logic               w_miss;
    logic               w_fall_step;
    logic               w_blink_vis;
    logic               w_visible;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .o_lfsr (w_lfsr)
    );

    // Only the low nine bits feed the spawn X; the rest just keep the sequence long.
    assign w_unused_lfsr = ^w_lfsr[15:9];

    assign w_spawn  = (r_state == IDLE) && bus.gameActive && bus.startOfFrame
                      && (r_frame_cnt == CNT_LAST);
    assign w_y_next = r_y + Y_STEP;
    assign w_miss   = (w_y_next >= Y_BOT);
    // A pickup or a freeze on a frame edge wins over the move.
    assign w_fall_step = (r_state == FALLING) && bus.gameActive && !bus.playerPickup
                         && bus.startOfFrame && !w_miss;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_spawn) begin
                    w_next = FALLING;
                end
            end
            FALLING: begin
                if (!bus.gameActive) begin
                    w_next = IDLE;
                end else if (bus.playerPickup) begin
                    w_next = COLLECTED;
                end else if (bus.startOfFrame && w_miss) begin
                    w_next = IDLE;
                end
            end
            COLLECTED: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_visible = 1'b0;
        if (r_state == FALLING) begin
            w_visible = w_blink_vis;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_x         <= X_LEFT;
            r_y         <= Y_TOP;
            r_type      <= PU_TURBO;
            r_turbo     <= 1'b0;
            r_god       <= 1'b0;
        end else begin
            // COLLECTED is only reachable from FALLING, so this fires once per object.
            r_turbo <= (w_next == COLLECTED) && (r_type == PU_TURBO);
            r_god   <= (w_next == COLLECTED) && (r_type == PU_GODMODE);

            if (w_spawn) begin
                r_frame_cnt <= '0;
                r_x         <= X_LEFT + {2'b00, w_lfsr[8:0]};
                r_y         <= Y_TOP;
                r_type      <= powerup_type_t'(w_lfsr[0]);
            end else if ((r_state == IDLE) && bus.gameActive && bus.startOfFrame) begin
                r_frame_cnt <= r_frame_cnt + CW'(1);
            end else if (r_state == COLLECTED) begin
                r_frame_cnt <= '0;
            end

            if (w_fall_step) begin
                r_y <= w_y_next;
            end
        end
    end

`ifdef POWERUP_BLINK_EN
    localparam logic signed [10:0] Y_BLINK = 11'(BOTTOM_Y - BLINK_ZONE);

    logic [2:0] r_blink_cnt;
    logic       r_blink_vis;

    // Every eighth frame inside the blink zone flips visibility; restarts lit on spawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= 3'd0;
            r_blink_vis <= 1'b1;
        end else if (w_spawn) begin
            r_blink_cnt <= 3'd0;
            r_blink_vis <= 1'b1;
        end else if ((r_state == FALLING) && bus.startOfFrame && (r_y >= Y_BLINK)) begin
            r_blink_cnt <= r_blink_cnt + 3'd1;
            if (r_blink_cnt == 3'd7) begin
                r_blink_vis <= ~r_blink_vis;
            end
        end
    end

    assign w_blink_vis = r_blink_vis;
`else
    assign w_blink_vis = 1'b1;
`endif

    assign bus.topLeftX         = r_x;
    assign bus.topLeftY         = r_y;
    assign bus.powerupVisible   = w_visible;
    assign bus.powerupType      = r_type;
    assign bus.TurboCollision   = r_turbo;
    assign bus.GodModeCollision = r_god;

endmodule

// File: tb/tb_powerup_drop_controller.sv
// Purpose : directed bench for powerup_drop_controller with a pulse scoreboard.
// Latency : expected collision pulses carry the cycle on which they must appear.
// Backpressure: n/a.
module tb_powerup_drop_controller;

    typedef struct {
        logic [1:0] pulses;   // {god, turbo}
        int         cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    int          cyc;
    int          n_chk;
    int          n_pass;
    logic [15:0] m_lfsr;
    exp_t        exp_q[$];
    int          cur_type;
    int          exp_x;
    int          exp_type;

    powerup_drop_controller_if bus ();

    powerup_drop_controller #(
        .SPAWN_FRAMES (4),
        .FALL_SPEED   (2),
        .TOP_Y        (0),
        .BOTTOM_Y     (10),
        .X_MIN        (32),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: taps 16,14,13,11 written out bit by bit.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        else             n_pass++;
    endtask

    // Monitor: every collision pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (bus.TurboCollision || bus.GodModeCollision)) begin
            if (exp_q.size() == 0) begin
                check("unexpected pulse", int'({bus.GodModeCollision, bus.TurboCollision}), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse kind", int'({bus.GodModeCollision, bus.TurboCollision}), int'(e.pulses));
                check("pulse cycle", cyc, e.cyc);
                check("vis during pulse", int'(bus.powerupVisible), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic expect_pulse(input int ptype);
        exp_t e;
        e.pulses = (ptype == 1) ? 2'b10 : 2'b01;
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Four frames to a spawn; optionally delays the last frame until the LFSR
    // will hand out the wanted type.
    task automatic spawn(input int want, input string nm);
        int n;
        frame(); frame(); frame();
        check({nm, " pre-spawn vis"}, int'(bus.powerupVisible), 0);
        n = 0;
        if (want >= 0) begin
            while ((int'(m_lfsr[0]) != want) && (n < 64)) begin
                tick(1);
                n++;
            end
            check({nm, " type wait"}, int'(n < 64), 1);
        end
        exp_x    = 32 + int'(m_lfsr[8:0]);
        exp_type = int'(m_lfsr[0]);
        frame();
        check({nm, " vis"},  int'(bus.powerupVisible), 1);
        check({nm, " Y"},    int'(bus.topLeftY), 0);
        check({nm, " X"},    int'(bus.topLeftX), exp_x);
        check({nm, " type"}, int'(bus.powerupType), exp_type);
        cur_type = exp_type;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0;
        reset = 1'b1;
        bus.gameActive   = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.playerPickup = 1'b0;
        tick(3);

        // Reset state
        check("rst vis",   int'(bus.powerupVisible), 0);
        check("rst X",     int'(bus.topLeftX), 32);
        check("rst Y",     int'(bus.topLeftY), 0);
        check("rst type",  int'(bus.powerupType), 0);
        check("rst turbo", int'(bus.TurboCollision), 0);
        check("rst god",   int'(bus.GodModeCollision), 0);
        reset = 1'b0;
        tick(1);

        // 1. spawn timing
        spawn(-1, "t1");

        // 2. fall and miss, then respawn as turbo
        for (int i = 1; i <= 4; i++) begin
            frame();
            check("t2 fall Y", int'(bus.topLeftY), 2 * i);
            check("t2 fall vis", int'(bus.powerupVisible), 1);
        end
        frame();
        check("t2 miss vis", int'(bus.powerupVisible), 0);
        check("t2 miss Y", int'(bus.topLeftY), 8);
        spawn(0, "t2 respawn");

        // 3. turbo pickup at Y=4
        frame(); frame();
        check("t3 Y", int'(bus.topLeftY), 4);
        bus.playerPickup = 1'b1;
        expect_pulse(0);
        tick(1);
        bus.playerPickup = 1'b0;
        check("t3 vis collected", int'(bus.powerupVisible), 0);
        tick(1);
        check("t3 vis idle", int'(bus.powerupVisible), 0);

        // 4. god-mode pickup coinciding with a frame at Y=6
        spawn(1, "t4");
        frame(); frame(); frame();
        check("t4 Y before", int'(bus.topLeftY), 6);
        bus.startOfFrame = 1'b1;
        bus.playerPickup = 1'b1;
        expect_pulse(1);
        tick(1);
        bus.startOfFrame = 1'b0;
        bus.playerPickup = 1'b0;
        check("t4 Y held", int'(bus.topLeftY), 6);
        check("t4 vis", int'(bus.powerupVisible), 0);
        tick(1);

        // 5. held pickup -> one pulse, counter restarts from zero
        spawn(-1, "t5");
        frame();
        bus.playerPickup = 1'b1;
        expect_pulse(cur_type);
        tick(20);
        bus.playerPickup = 1'b0;
        check("t5 vis after hold", int'(bus.powerupVisible), 0);
        spawn(-1, "t5 restart");

        // 6a. reset mid-fall
        frame(); frame(); frame();
        check("t6 Y before reset", int'(bus.topLeftY), 6);
        reset = 1'b1;
        #1;
        check("t6 rst vis", int'(bus.powerupVisible), 0);
        check("t6 rst X",   int'(bus.topLeftX), 32);
        check("t6 rst Y",   int'(bus.topLeftY), 0);
        check("t6 rst type", int'(bus.powerupType), 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // 6b. gameActive low holds the frame counter
        frame(); frame();
        bus.gameActive = 1'b0;
        frame(); frame(); frame();
        check("t6 frozen vis", int'(bus.powerupVisible), 0);
        bus.gameActive = 1'b1;
        frame();
        check("t6 one after resume", int'(bus.powerupVisible), 0);
        exp_x    = 32 + int'(m_lfsr[8:0]);
        exp_type = int'(m_lfsr[0]);
        frame();
        check("t6 spawn vis",  int'(bus.powerupVisible), 1);
        check("t6 spawn X",    int'(bus.topLeftX), exp_x);
        check("t6 spawn type", int'(bus.powerupType), exp_type);

        tick(3);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
